// File: rtl/prim_rec_ctrl_if.sv
// Bundle of the start/result handshake and the g/h sub-block handshakes
// around the primitive-recursion controller. Clock and reset stay outside.
interface prim_rec_ctrl_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
);
    logic             ST;
    logic [CNT_W-1:0] IN_N;
    logic             RD;
    logic [WIDTH-1:0] RES;
    logic             ERR;
    logic             G_ST;
    logic             G_RD;
    logic [WIDTH-1:0] G_RES;
    logic             H_ST;
    logic             H_RD;
    logic [WIDTH-1:0] H_RES;
    logic [CNT_W-1:0] H_IDX;
    logic [WIDTH-1:0] H_ACC;

    // Controller side
    modport master (
        input  ST, IN_N, G_RD, G_RES, H_RD, H_RES,
        output RD, RES, ERR, G_ST, H_ST, H_IDX, H_ACC
    );

    // Requester / sub-block side
    modport slave (
        output ST, IN_N, G_RD, G_RES, H_RD, H_RES,
        input  RD, RES, ERR, G_ST, H_ST, H_IDX, H_ACC
    );
endinterface

// File: rtl/prim_rec_ctrl.sv
// Sequencer for primitive recursion f(0)=g, f(i+1)=h(i,f(i)) (MODE 0) or
// bounded minimisation mu i.h(i)=0 with an iteration bound (MODE 1).
// The g and h blocks are external; this block issues one-cycle start pulses
// and reacts only to rising edges of their ready lines.
module prim_rec_ctrl #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16,
    parameter int MODE  = 0,
    parameter int LIMIT = 65535
) (
    input  logic           CLK,
    input  logic           RST,
    prim_rec_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        G_RUN = 2'd1,
        H_RUN = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

    state_t           state, state_nxt;
    logic             st_p0, g_rd_p0, h_rd_p0;
    logic             armed_p0;
    logic [CNT_W-1:0] n_q, n_nxt;
    logic [CNT_W-1:0] idx_q, idx_nxt, idx_inc;
    logic [WIDTH-1:0] acc_q, acc_nxt;
    logic [WIDTH-1:0] res_q, res_nxt;
    logic             err_q, err_nxt;
    logic             rd_q, rd_nxt;
    logic             g_st_q, g_st_nxt;
    logic             h_st_q, h_st_nxt;
    logic             st_edge, g_edge, h_edge;

    // Zero-extend or truncate an index to the result width.
    function automatic logic [WIDTH-1:0] idx_to_res(input logic [CNT_W-1:0] v);
        logic [WIDTH+CNT_W-1:0] wide;
        wide = {{WIDTH{1'b0}}, v};
        return wide[WIDTH-1:0];
    endfunction

    // A start needs one clean sample after reset first, so an ST held high
    // through reset release is never mistaken for a fresh request.
    assign st_edge = bus.ST & ~st_p0 & armed_p0;
    assign g_edge  = bus.G_RD & ~g_rd_p0;
    assign h_edge  = bus.H_RD & ~h_rd_p0;

    // State, edge-detect history and all output registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            st_p0    <= 1'b0;
            g_rd_p0  <= 1'b0;
            h_rd_p0  <= 1'b0;
            armed_p0 <= 1'b0;
            n_q      <= '0;
            idx_q    <= '0;
            acc_q    <= '0;
            res_q    <= '0;
            err_q    <= 1'b0;
            rd_q     <= 1'b1;
            g_st_q   <= 1'b0;
            h_st_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            st_p0    <= bus.ST;
            g_rd_p0  <= bus.G_RD;
            h_rd_p0  <= bus.H_RD;
            armed_p0 <= 1'b1;
            n_q      <= n_nxt;
            idx_q    <= idx_nxt;
            acc_q    <= acc_nxt;
            res_q    <= res_nxt;
            err_q    <= err_nxt;
            rd_q     <= rd_nxt;
            g_st_q   <= g_st_nxt;
            h_st_q   <= h_st_nxt;
        end
    end

    // Next-state and next-output decision; start pulses default low so each
    // lasts exactly one cycle.
    always_comb begin
        state_nxt = state;
        n_nxt     = n_q;
        idx_nxt   = idx_q;
        acc_nxt   = acc_q;
        res_nxt   = res_q;
        err_nxt   = err_q;
        rd_nxt    = rd_q;
        g_st_nxt  = 1'b0;
        h_st_nxt  = 1'b0;
        idx_inc   = idx_q + CNT_W'(1);
        case (state)
            IDLE: begin
                if (st_edge) begin
                    rd_nxt  = 1'b0;
                    n_nxt   = bus.IN_N;
                    idx_nxt = '0;
                    err_nxt = 1'b0;
                    if (MODE == 0) begin
                        g_st_nxt  = 1'b1;
                        state_nxt = G_RUN;
                    end else begin
                        acc_nxt   = '0;
                        h_st_nxt  = 1'b1;
                        state_nxt = H_RUN;
                    end
                end
            end
            G_RUN: begin
                if (g_edge) begin
                    acc_nxt = bus.G_RES;
                    if (n_q == '0) begin
                        res_nxt   = bus.G_RES;
                        rd_nxt    = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        h_st_nxt  = 1'b1;
                        state_nxt = H_RUN;
                    end
                end
            end
            H_RUN: begin
                if (h_edge) begin
                    acc_nxt = bus.H_RES;
                    if (MODE == 0) begin
                        // Compare the incremented index so n = 2^CNT_W-1 ends before wrap.
                        idx_nxt = idx_inc;
                        if (idx_inc == n_q) begin
                            res_nxt   = bus.H_RES;
                            rd_nxt    = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            h_st_nxt = 1'b1;
                        end
                    end else begin
                        if (bus.H_RES == '0) begin
                            res_nxt   = idx_to_res(idx_q);
                            rd_nxt    = 1'b1;
                            state_nxt = IDLE;
                        end else if (idx_inc == LIMIT_C) begin
                            res_nxt   = '1;
                            err_nxt   = 1'b1;
                            rd_nxt    = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            idx_nxt  = idx_inc;
                            h_st_nxt = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                rd_nxt    = 1'b1;
            end
        endcase
    end

    assign bus.RD    = rd_q;
    assign bus.RES   = res_q;
    assign bus.ERR   = err_q;
    assign bus.G_ST  = g_st_q;
    assign bus.H_ST  = h_st_q;
    assign bus.H_IDX = idx_q;
    assign bus.H_ACC = acc_q;

endmodule
